// File: rtl/inpack_pkg.sv
// inpack_pkg: shared state encoding, pixel field offsets and word packing helper for inpack
package inpack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DROP
    } state_t;

    localparam int SYNC_BIT = 24;
    localparam int R_HI     = 23;
    localparam int R_LO     = 16;
    localparam int G_HI     = 15;
    localparam int G_LO     = 8;
    localparam int B_HI     = 7;
    localparam int B_LO     = 0;
    localparam int PIXW     = 24;
    localparam int WORDW    = 32;

    // Three words carry four pixels; phase selects which bytes of the previous
    // and current pixel complete the word (phase 0 never completes a word).
    function automatic logic [WORDW-1:0] pack_word(
        input logic [1:0]      ph,
        input logic [PIXW-1:0] prev,
        input logic [PIXW-1:0] cur
    );
        return (ph == 2'd1) ? {cur[B_HI:B_LO], prev} :
               (ph == 2'd2) ? {cur[G_HI:B_LO], prev[R_HI:G_LO]} :
                              {cur, prev[R_HI:R_LO]};
    endfunction

endpackage

// File: rtl/inpack_fifo.sv
// inpack_fifo: first-word fall-through FIFO; push refused when full even if popping the same cycle
module inpack_fifo #(
    parameter int W  = 56,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers and occupancy; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/inpack.sv
// inpack: packs 24-bit pixels into 32-bit words with double-buffered frame addresses; optional INPACK_FRAMECNT_EN adds per-frame pixel count
module inpack
    import inpack_pkg::*;
#(
    parameter int FIFOAW     = 4,
    parameter int ADDRW      = 24,
    parameter int FRAMEWORDS = 388800
) (
    input  logic             adclk,
    input  logic             rstn,
    input  logic             inde,
    input  logic [24:0]      indat,
    output logic             wvalid,
    input  logic             wready,
    output logic [31:0]      wdata,
    output logic [ADDRW-1:0] waddr,
    output logic             curframe,
    output logic             ovf,
    input  logic             ovfclr
`ifdef INPACK_FRAMECNT_EN
    ,
    output logic [23:0]      lastcnt,
    output logic             cntvalid
`endif
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_phase;
    logic [ADDRW-1:0]      r_widx;
    logic [PIXW-1:0]       r_prev;
    logic                  r_curframe;
    logic                  r_ovf;
    logic                  w_sync;
    logic                  w_accept;
    logic [1:0]            w_ph;
    logic [ADDRW-1:0]      w_idx;
    logic                  w_gen;
    logic                  w_inrange;
    logic                  w_want;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_drop;
    logic                  w_push;
    logic                  w_toggle;
    logic [ADDRW-1:0]      w_base;
    logic [WORDW+ADDRW-1:0] w_wentry;
    logic [WORDW+ADDRW-1:0] w_rentry;

    // A sync pixel restarts packing at pixel 0 / word 0 regardless of state
    assign w_sync    = inde && indat[SYNC_BIT];
    assign w_accept  = inde && (r_state == RUN || w_sync);
    assign w_ph      = w_sync ? 2'd0 : r_phase;
    assign w_idx     = w_sync ? '0 : r_widx;
    assign w_gen     = w_accept && w_ph != 2'd0;
    assign w_inrange = w_idx < ADDRW'(FRAMEWORDS);
    assign w_want    = w_gen && w_inrange;
    assign w_drop    = w_want && w_full;
    assign w_push    = w_want && !w_full;
    assign w_base    = r_curframe ? ADDRW'(FRAMEWORDS) : '0;
    assign w_wentry  = {w_base + w_idx, pack_word(w_ph, r_prev, indat[PIXW-1:0])};

    assign wvalid   = !w_empty;
    assign wdata    = w_rentry[WORDW-1:0];
    assign waddr    = w_rentry[WORDW +: ADDRW];
    assign curframe = r_curframe;
    assign ovf      = r_ovf;

    inpack_fifo #(
        .W  (WORDW + ADDRW),
        .AW (FIFOAW)
    ) u_fifo (
        .clk     (adclk),
        .rst_n   (rstn),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (wvalid && wready),
        .o_rdata (w_rentry),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register
    always_ff @(posedge adclk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and frame toggle from the sync marker and overflow drop
    always_comb begin
        w_state_nxt = r_state;
        w_toggle    = 1'b0;
        if (w_sync) begin
            w_state_nxt = RUN;
            w_toggle    = r_state != IDLE;
        end else if (w_drop) begin
            w_state_nxt = DROP;
        end
    end

    // Pack phase, word index, residue pixel, frame select and sticky overflow
    always_ff @(posedge adclk or negedge rstn) begin
        if (!rstn) begin
            r_phase    <= '0;
            r_widx     <= '0;
            r_prev     <= '0;
            r_curframe <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_phase <= w_ph + 2'd1;
                r_prev  <= indat[PIXW-1:0];
                r_widx  <= w_want ? w_idx + ADDRW'(1) : w_idx;
            end
            if (w_toggle) r_curframe <= !r_curframe;
            r_ovf <= w_drop || (r_ovf && !ovfclr);
        end
    end

`ifdef INPACK_FRAMECNT_EN
    logic [23:0] r_pcnt;
    logic [23:0] r_lastcnt;
    logic        r_cntvalid;

    assign lastcnt  = r_lastcnt;
    assign cntvalid = r_cntvalid;

    // Count every pixel seen since the last frame start, including dropped ones
    always_ff @(posedge adclk or negedge rstn) begin
        if (!rstn) begin
            r_pcnt     <= '0;
            r_lastcnt  <= '0;
            r_cntvalid <= 1'b0;
        end else begin
            r_cntvalid <= 1'b0;
            if (w_sync) begin
                if (r_state != IDLE) begin
                    r_lastcnt  <= r_pcnt;
                    r_cntvalid <= 1'b1;
                end
                r_pcnt <= 24'd1;
            end else if (inde && r_state != IDLE) begin
                r_pcnt <= r_pcnt + 24'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inpack.sv
// tb_inpack: table-driven, directed and randomized checks of inpack against a byte-stream reference model
module tb_inpack;

    localparam int FW = 388800;

    logic        adclk  = 1'b0;
    logic        rstn   = 1'b0;
    logic        inde   = 1'b0;
    logic [24:0] indat  = '0;
    logic        wready = 1'b0;
    logic        ovfclr = 1'b0;
    logic        wvalid;
    logic [31:0] wdata;
    logic [23:0] waddr;
    logic        curframe;
    logic        ovf;
`ifdef INPACK_FRAMECNT_EN
    logic [23:0] lastcnt;
    logic        cntvalid;
`endif

    always #5 adclk = ~adclk;

    inpack dut (
        .adclk    (adclk),
        .rstn     (rstn),
        .inde     (inde),
        .indat    (indat),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .waddr    (waddr),
        .curframe (curframe),
        .ovf      (ovf),
        .ovfclr   (ovfclr)
`ifdef INPACK_FRAMECNT_EN
        ,
        .lastcnt  (lastcnt),
        .cntvalid (cntvalid)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef enum {M_IDLE, M_RUN, M_DROP} mst_t;
    mst_t        m_st;
    logic        m_frame;
    logic        m_ovf;
    int          m_idx;
    logic [7:0]  m_bytes[$];
    logic [55:0] m_q[$];
    int          m_pcnt;
    logic [23:0] m_last;
    logic        m_cv;

    function automatic void model_reset();
        m_st    = M_IDLE;
        m_frame = 1'b0;
        m_ovf   = 1'b0;
        m_idx   = 0;
        m_pcnt  = 0;
        m_last  = '0;
        m_cv    = 1'b0;
        m_bytes.delete();
        m_q.delete();
    endfunction

    function automatic void model_step(input logic de, input logic [24:0] d, input logic wr, input logic clr);
        int          occ;
        logic        pop;
        logic        drop;
        logic        have;
        logic [31:0] w;
        logic [23:0] a;
        occ  = m_q.size();
        pop  = occ > 0 && wr;
        drop = 1'b0;
        have = 1'b0;
        w    = '0;
        a    = '0;
        m_cv = 1'b0;
        if (de) begin
            if (d[24]) begin
                if (m_st != M_IDLE) begin
                    m_frame = ~m_frame;
                    m_last  = 24'(m_pcnt);
                    m_cv    = 1'b1;
                end
                m_pcnt = 0;
                m_st   = M_RUN;
                m_idx  = 0;
                m_bytes.delete();
            end
            if (m_st != M_IDLE) m_pcnt++;
            if (m_st == M_RUN) begin
                m_bytes.push_back(d[7:0]);
                m_bytes.push_back(d[15:8]);
                m_bytes.push_back(d[23:16]);
                if (m_bytes.size() >= 4) begin
                    w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    for (int k = 0; k < 4; k++) void'(m_bytes.pop_front());
                    if (m_idx < FW) begin
                        if (occ >= 16) begin
                            drop = 1'b1;
                            m_st = M_DROP;
                        end else begin
                            have = 1'b1;
                            a    = 24'((m_frame ? FW : 0) + m_idx);
                        end
                    end
                    m_idx++;
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (have) m_q.push_back({a, w});
        m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    endfunction

    task automatic check_outputs();
        chk("wvalid", wvalid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("wdata", wdata, m_q[0][31:0]);
            chk("waddr", waddr, m_q[0][55:32]);
        end
        chk("ovf", ovf, m_ovf);
        chk("curframe", curframe, m_frame);
`ifdef INPACK_FRAMECNT_EN
        chk("cntvalid", cntvalid, m_cv);
        if (m_cv) chk("lastcnt", lastcnt, m_last);
`endif
    endtask

    // Called at a falling edge: drive, let the rising edge sample, update model, compare at next falling edge
    task automatic cycle(input logic de, input logic [24:0] d, input logic wr, input logic clr);
        inde   = de;
        indat  = d;
        wready = wr;
        ovfclr = clr;
        @(posedge adclk);
        model_step(de, d, wr, clr);
        @(negedge adclk);
        check_outputs();
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        inde   = 1'b0;
        indat  = '0;
        wready = 1'b0;
        ovfclr = 1'b0;
        #1;
        model_reset();
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_curframe", curframe, 0);
        @(negedge adclk);
        rstn = 1'b1;
    endtask

    typedef struct {
        logic        de;
        logic [24:0] d;
        logic        wr;
        logic        ev;
        logic [31:0] ed;
        logic [23:0] ea;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b1, 25'h1112233, 1'b1, 1'b0, 32'h0,        24'd0};
        tbl[1] = '{1'b1, 25'h0445566, 1'b1, 1'b1, 32'h66112233, 24'd0};
        tbl[2] = '{1'b1, 25'h0778899, 1'b1, 1'b1, 32'h88994455, 24'd1};
        tbl[3] = '{1'b1, 25'h0AABBCC, 1'b1, 1'b1, 32'hAABBCC77, 24'd2};
        tbl[4] = '{1'b0, 25'h0000000, 1'b1, 1'b0, 32'h0,        24'd0};

        do_reset();

        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].de, tbl[i].d, tbl[i].wr, 1'b0);
            chk("tbl_wvalid", wvalid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk("tbl_wdata", wdata, tbl[i].ed);
                chk("tbl_waddr", waddr, tbl[i].ea);
            end
            chk("tbl_curframe", curframe, 0);
        end

        for (int i = 4; i < 8; i++) cycle(1'b1, 25'(i * 32'h030303), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 25'h1010203, 1'b1, 1'b0);
        chk("frame2_curframe", curframe, 1);
        cycle(1'b1, 25'h0040506, 1'b1, 1'b0);
        chk("frame2_w0_data", wdata, 32'h06010203);
        chk("frame2_w0_addr", waddr, 24'd388800);
        cycle(1'b1, 25'h0070809, 1'b1, 1'b0);
        chk("frame2_w1_data", wdata, 32'h08090405);
        chk("frame2_w1_addr", waddr, 24'd388801);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        cycle(1'b1, 25'h1C0C1C2, 1'b1, 1'b0);
        cycle(1'b1, 25'h0D0D1D2, 1'b1, 1'b0);
        cycle(1'b1, 25'h1E0E1E2, 1'b1, 1'b0);
        cycle(1'b1, 25'h0F0F1F2, 1'b1, 1'b0);
        chk("resync_data", wdata, 32'hF2E0E1E2);
        chk("resync_addr", waddr, 24'd388800);
        chk("resync_curframe", curframe, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) cycle(1'b1, {i == 0, 24'($urandom)}, 1'b0, 1'b0);
        chk("ovf_set", ovf, 1);
        chk("ovf_wvalid", wvalid, 1);
        for (int i = 0; i < 20; i++) cycle(1'b1, {1'b0, 24'($urandom)}, 1'b1, 1'b0);
        chk("drop_drained", wvalid, 0);
        chk("ovf_sticky", ovf, 1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("ovf_cleared", ovf, 0);
        cycle(1'b1, 25'h1123456, 1'b1, 1'b0);
        chk("drop_resync_frame", curframe, 1);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, {1'b0, 24'($urandom)}, 1'b1, 1'b0);
            chk("presync_wvalid", wvalid, 0);
        end

        for (int i = 0; i < 7; i++) cycle(1'b1, {i == 0, 24'($urandom)}, 1'b0, 1'b0);
        chk("five_words_wvalid", wvalid, 1);
        chk("five_words_count", m_q.size(), 5);
        #2;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, {1'b0, 24'($urandom)}, 1'b1, 1'b0);
            chk("postrst_wvalid", wvalid, 0);
        end

        for (int i = 0; i < 3000; i++) begin
            logic de;
            logic sy;
            logic wr;
            de = $urandom_range(0, 3) != 0;
            sy = $urandom_range(0, 59) == 0;
            wr = ((i / 400) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
            cycle(de, {sy, 24'($urandom)}, wr, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
